// File: rtl/custom_ip_scheduler.sv
// custom_ip_scheduler: round-robin sharing of one custom_ip engine between NUM_REQ requesters.
// Ports: req_valid/req_data/req_ready (request accept), rsp_valid/rsp_ready/rsp_data/rsp_err
// (response to owner), ip_ctrl_enable/ip_data_in/ip_status_busy/ip_data_out (engine side),
// sched_busy/grant_id (status). clk, rst_n (async, active-low).
module custom_ip_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int START_TO   = 4,
  parameter int DONE_TO    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          ip_ctrl_enable,
  output logic [DATA_WIDTH-1:0]         ip_data_in,
  input  logic                          ip_status_busy,
  input  logic [DATA_WIDTH-1:0]         ip_data_out,
  output logic                          sched_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CMAX = (DONE_TO > START_TO) ? DONE_TO : START_TO;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ip_data_in_q, ip_data_in_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  win_found;
  logic [IDW-1:0]        win_idx;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic [NUM_REQ-1:0]    rsp_valid_c;

  // Round-robin search: first valid requester after the last owner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    ip_data_in_d = ip_data_in_q;
    grant_id_d   = grant_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req_ready_c  = '0;
    rsp_valid_c  = '0;
    ip_ctrl_enable = 1'b0;
    case (state_q)
      IDLE: begin
        // Engine may still be finishing a timed-out job; never start over it.
        if (win_found && !ip_status_busy) begin
          req_ready_c[win_idx] = 1'b1;
          ip_data_in_d = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
          grant_id_d   = win_idx;
          ptr_d        = win_idx;
          cnt_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        ip_ctrl_enable = 1'b1;
        cnt_d          = '0;
        state_d        = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (ip_status_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(START_TO - 1)) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = RESP;
          end
        end
      end
      WAIT_DONE: begin
        // Completion wins over timeout when both happen in the same cycle.
        if (!ip_status_busy) begin
          rsp_data_d = ip_data_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DONE_TO - 1)) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        rsp_valid_c[grant_id_q] = 1'b1;
        if (rsp_ready[grant_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NUM_REQ - 1);
      cnt_q        <= '0;
      ip_data_in_q <= '0;
      grant_id_q   <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      ip_data_in_q <= ip_data_in_d;
      grant_id_q   <= grant_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The accept pulse is combinational; mask it so it is quiet while reset is held.
  assign req_ready  = req_ready_c & {NUM_REQ{rst_n}};
  assign rsp_valid  = rsp_valid_c;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign ip_data_in = ip_data_in_q;
  assign grant_id   = grant_id_q;
  assign sched_busy = (state_q != IDLE);

endmodule
